// File: rtl/fp_int_mac_vec_if.sv
// rtl/fp_int_mac_vec_if.sv - stream/result bundle for the FP16 x INT dot-product MAC
// Purpose: groups the input beat handshake and the result handshake.
// Ports (signals):
//   in_valid/in_ready/in_last  input beat handshake, in_last closes a vector
//   activation                 LANES x FP16, lane i = [16*i +: 16]
//   weight                     LANES x W_WIDTH integers, lane i = [W_WIDTH*i +: W_WIDTH]
//   signed_w, exp_min          per-beat weight signedness and alignment floor
//   out_valid/out_ready        result handshake
//   acc_out, overflow          result and its saturation / Inf-NaN flag
// master = beat producer and result consumer, slave = the MAC.
interface fp_int_mac_vec_if #(
  parameter int LANES     = 4,
  parameter int W_WIDTH   = 4,
  parameter int ACC_WIDTH = 32
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_last;
  logic [LANES*16-1:0]        activation;
  logic [LANES*W_WIDTH-1:0]   weight;
  logic                       signed_w;
  logic [4:0]                 exp_min;
  logic                       out_valid;
  logic                       out_ready;
  logic [ACC_WIDTH-1:0]       acc_out;
  logic                       overflow;

  modport master (
    output in_valid, in_last, activation, weight, signed_w, exp_min, out_ready,
    input  in_ready, out_valid, acc_out, overflow
  );

  modport slave (
    input  in_valid, in_last, activation, weight, signed_w, exp_min, out_ready,
    output in_ready, out_valid, acc_out, overflow
  );
endinterface

// File: rtl/fp_int_mac_vec.sv
// rtl/fp_int_mac_vec.sv - LANES-wide FP16 x INT dot-product MAC with saturating accumulator
// Purpose: per beat, decode FP16 activations, multiply by integer weights, align to the
//   exp_min floor, sum all lanes and accumulate with saturation; in_last emits the result.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   io_bus   fp_int_mac_vec_if.slave (beat input, result output)
//   o_busy   a pipeline stage or the accumulator holds live data
// Pipeline: s1 decode/multiply, s2 align/clamp/sign, s3 lane sum, then accumulator.
module fp_int_mac_vec #(
  parameter int LANES     = 4,
  parameter int W_WIDTH   = 4,
  parameter int ACC_WIDTH = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  fp_int_mac_vec_if.slave io_bus,
  output logic            o_busy
);
  localparam int PW = 11 + W_WIDTH;
  localparam int LG = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int TW = ACC_WIDTH + LG;
  // wide enough to hold the largest left shift (30) without losing bits
  localparam int XW = (PW + 31 > ACC_WIDTH) ? PW + 31 : ACC_WIDTH;
  localparam logic [XW-1:0] MAG_MAX = {{(XW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [TW:0] SUM_MAX = {{(LG+2){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [TW:0] SUM_MIN = {{(LG+2){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [W_WIDTH-1:0] ONE_W = {{(W_WIDTH-1){1'b0}}, 1'b1};

  logic                        w_en, r_rdy;
  logic                        r_out_valid, r_overflow;
  logic signed [ACC_WIDTH-1:0] r_acc_out;

  // stalls only while a result is presented and not taken
  assign w_en = !(r_out_valid && !io_bus.out_ready);

  // stage 1: decode and unsigned product
  logic                 w_d_neg  [LANES];
  logic [W_WIDTH-1:0]   w_d_absw [LANES];
  logic [4:0]           w_d_e    [LANES];
  logic [PW-1:0]        w_d_p    [LANES];
  logic                 w_d_inf;
  logic                 r_s1_v, r_s1_last, r_s1_inf;
  logic [4:0]           r_s1_em;
  logic                 r_s1_sgn [LANES];
  logic [4:0]           r_s1_e   [LANES];
  logic [PW-1:0]        r_s1_p   [LANES];

  always_comb begin
    w_d_inf = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      w_d_e[i]    = io_bus.activation[16*i+10 +: 5];
      w_d_neg[i]  = io_bus.signed_w & io_bus.weight[W_WIDTH*i + W_WIDTH-1];
      // two's complement negate; the most negative weight maps to 2^(W-1) unsigned
      w_d_absw[i] = w_d_neg[i] ? (~io_bus.weight[W_WIDTH*i +: W_WIDTH] + ONE_W)
                               : io_bus.weight[W_WIDTH*i +: W_WIDTH];
      if (w_d_e[i] == 5'd0 || w_d_e[i] == 5'd31)
        w_d_p[i] = '0;
      else
        w_d_p[i] = PW'({1'b1, io_bus.activation[16*i +: 10]}) * PW'(w_d_absw[i]);
      if (w_d_e[i] == 5'd31)
        w_d_inf = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdy     <= 1'b0;
      r_s1_v    <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_inf  <= 1'b0;
      r_s1_em   <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_s1_sgn[i] <= 1'b0;
        r_s1_e[i]   <= '0;
        r_s1_p[i]   <= '0;
      end
    end else begin
      r_rdy <= 1'b1;
      if (w_en) begin
        r_s1_v    <= io_bus.in_valid & r_rdy;
        r_s1_last <= io_bus.in_last;
        r_s1_inf  <= w_d_inf;
        r_s1_em   <= io_bus.exp_min;
        for (int i = 0; i < LANES; i++) begin
          r_s1_sgn[i] <= io_bus.activation[16*i+15] ^ w_d_neg[i];
          r_s1_e[i]   <= w_d_e[i];
          r_s1_p[i]   <= w_d_p[i];
        end
      end
    end
  end

  // stage 2: align to exp_min, clamp magnitude, apply sign
  logic [XW-1:0]               w_sh    [LANES];
  logic [ACC_WIDTH-1:0]        w_a_mag [LANES];
  logic signed [ACC_WIDTH-1:0] w_a_val [LANES];
  logic                        w_a_flag;
  logic                        r_s2_v, r_s2_last, r_s2_flag;
  logic signed [ACC_WIDTH-1:0] r_s2_val [LANES];

  always_comb begin
    w_a_flag = r_s1_inf;
    for (int i = 0; i < LANES; i++) begin
      if (r_s1_e[i] >= r_s1_em)
        w_sh[i] = XW'(r_s1_p[i]) << (r_s1_e[i] - r_s1_em);
      else
        w_sh[i] = XW'(r_s1_p[i]) >> (r_s1_em - r_s1_e[i]);
      if (w_sh[i] > MAG_MAX) begin
        w_a_mag[i] = ACC_MAX;
        w_a_flag   = 1'b1;
      end else begin
        w_a_mag[i] = w_sh[i][ACC_WIDTH-1:0];
      end
      w_a_val[i] = r_s1_sgn[i] ? -$signed(w_a_mag[i]) : $signed(w_a_mag[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_v    <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_flag <= 1'b0;
      for (int i = 0; i < LANES; i++) r_s2_val[i] <= '0;
    end else if (w_en) begin
      r_s2_v    <= r_s1_v;
      r_s2_last <= r_s1_last;
      r_s2_flag <= w_a_flag;
      for (int i = 0; i < LANES; i++) r_s2_val[i] <= w_a_val[i];
    end
  end

  // stage 3: exact lane sum, log2(LANES) guard bits
  logic signed [TW-1:0] w_tree, r_s3_sum;
  logic                 r_s3_v, r_s3_last, r_s3_flag;

  always_comb begin
    w_tree = '0;
    for (int i = 0; i < LANES; i++) w_tree = w_tree + TW'(r_s2_val[i]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s3_v    <= 1'b0;
      r_s3_last <= 1'b0;
      r_s3_flag <= 1'b0;
      r_s3_sum  <= '0;
    end else if (w_en) begin
      r_s3_v    <= r_s2_v;
      r_s3_last <= r_s2_last;
      r_s3_flag <= r_s2_flag;
      r_s3_sum  <= w_tree;
    end
  end

  // accumulator with saturation; in_last loads the result and clears for the next vector
  logic signed [ACC_WIDTH-1:0] r_acc, w_acc_next;
  logic signed [TW:0]          w_sum;
  logic                        w_sat, w_vflag, r_vflag, r_partial;

  always_comb begin
    w_sum = (TW+1)'(r_acc) + (TW+1)'(r_s3_sum);
    w_sat = 1'b1;
    if (w_sum > SUM_MAX)
      w_acc_next = ACC_MAX;
    else if (w_sum < SUM_MIN)
      w_acc_next = ACC_MIN;
    else begin
      w_acc_next = w_sum[ACC_WIDTH-1:0];
      w_sat      = 1'b0;
    end
    w_vflag = r_vflag | r_s3_flag | w_sat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc       <= '0;
      r_vflag     <= 1'b0;
      r_partial   <= 1'b0;
      r_acc_out   <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      if (r_out_valid && io_bus.out_ready)
        r_out_valid <= 1'b0;
      if (r_s3_v) begin
        if (r_s3_last) begin
          r_acc_out   <= w_acc_next;
          r_overflow  <= w_vflag;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_vflag     <= 1'b0;
          r_partial   <= 1'b0;
        end else begin
          r_acc     <= w_acc_next;
          r_vflag   <= w_vflag;
          r_partial <= 1'b1;
        end
      end
    end
  end

  assign io_bus.in_ready  = w_en & r_rdy;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.acc_out   = r_acc_out;
  assign io_bus.overflow  = r_overflow;
  assign o_busy           = r_s1_v | r_s2_v | r_s3_v | r_partial;
endmodule

// File: tb/tb_fp_int_mac_vec.sv
// tb/tb_fp_int_mac_vec.sv - self-checking bench for fp_int_mac_vec
module tb_fp_int_mac_vec;
  localparam int L = 4, W = 4, A = 32;
  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  fp_int_mac_vec_if #(.LANES(L), .W_WIDTH(W), .ACC_WIDTH(A)) bus();

  fp_int_mac_vec #(.LANES(L), .W_WIDTH(W), .ACC_WIDTH(A)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .io_bus(bus),
    .o_busy(busy)
  );

  typedef struct {longint acc; bit ovf;} res_t;
  res_t   exp_q[$];
  res_t   got_q[$];
  longint m_acc = 0;
  bit     m_flag = 0;
  int     checks = 0, passes = 0;
  int     cyc = 0;
  bit     rnd_ready = 0;
  bit     ready_force = 1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    else           bus.out_ready = ready_force;
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // value of one lane: real product magnitude scaled by 2^(25-exp_min), truncated
  function automatic void lane_model(input logic [15:0] a, input logic [3:0] w, input bit sw,
                                     input int em, output longint v, output bit f);
    int e;
    int wi;
    longint mag;
    e = int'(a[14:10]);
    wi = sw ? int'($signed(w)) : int'(w);
    v = 0;
    f = (e == 31);
    if (e == 0 || e == 31) return;
    mag = longint'({1'b1, a[9:0]}) * longint'(wi < 0 ? -wi : wi);
    if (e >= em) mag = mag * (64'sd1 << (e - em));
    else         mag = mag / (64'sd1 << (em - e));
    if (mag > AMAX) begin
      mag = AMAX;
      f = 1;
    end
    v = ((a[15] == 1'b1) != (wi < 0)) ? -mag : mag;
  endfunction

  function automatic void model_beat(input logic [63:0] act, input logic [15:0] wt, input bit sw,
                                     input logic [4:0] em, input bit last);
    longint s, v;
    bit f, lf;
    res_t r;
    s = 0;
    f = 0;
    for (int i = 0; i < L; i++) begin
      lane_model(act[16*i +: 16], wt[4*i +: 4], sw, int'(em), v, lf);
      s += v;
      f |= lf;
    end
    m_acc += s;
    if (m_acc > AMAX) begin m_acc = AMAX; f = 1; end
    else if (m_acc < AMIN) begin m_acc = AMIN; f = 1; end
    m_flag |= f;
    if (last) begin
      r.acc = m_acc;
      r.ovf = m_flag;
      exp_q.push_back(r);
      m_acc = 0;
      m_flag = 0;
    end
  endfunction

  // drives a beat at negedge, holds it until accepted at the following posedge
  task automatic send(input logic [63:0] act, input logic [15:0] wt, input bit sw,
                      input logic [4:0] em, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.activation = act;
    bus.weight = wt;
    bus.signed_w = sw;
    bus.exp_min = em;
    bus.in_last = last;
    #1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) check("accept_timeout", longint'(bus.in_ready), 1);
    else model_beat(act, wt, sw, em, last);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || bus.out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) check("drain_timeout", longint'(exp_q.size()), 0);
  endtask

  task automatic run_vec(input string name, input logic [63:0] act, input logic [15:0] wt,
                         input bit sw, input longint lit_acc, input bit lit_ovf);
    drain();
    send(act, wt, sw, 5'd15, 1'b1);
    idle();
    drain();
    check({name, "_acc"}, got_q[$].acc, lit_acc);
    check({name, "_ovf"}, longint'(got_q[$].ovf), longint'(lit_ovf));
  endtask

  // compare process: every accepted result against the model, plus stall behaviour
  logic [31:0] prev_acc;
  bit          prev_stall = 0;
  always @(negedge clk) begin
    res_t r, g;
    #2;
    if (rst_n) begin
      if (prev_stall) check("acc_out_stable", longint'(bus.acc_out), longint'(prev_acc));
      if (bus.out_valid && !bus.out_ready) check("in_ready_stall", longint'(bus.in_ready), 0);
      if (bus.out_valid && bus.out_ready) begin
        g.acc = longint'($signed(bus.acc_out));
        g.ovf = bus.overflow;
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: got %0d expected none", g.acc);
        end else begin
          r = exp_q.pop_front();
          check("acc_out", g.acc, r.acc);
          check("overflow", longint'(g.ovf), longint'(r.ovf));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_acc = bus.acc_out;
    end else begin
      prev_stall = 0;
    end
  end

  function automatic logic [15:0] rnd_act(input int em);
    int e, r;
    r = $urandom_range(0, 49);
    if (r == 0) e = 0;
    else if (r == 1) e = 31;
    else begin
      e = em - 12 + int'($urandom_range(0, 29));
      if (e < 1) e = 1;
      if (e > 30) e = 30;
    end
    return {1'($urandom_range(0, 1)), 5'(e), 10'($urandom)};
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int t0, n, base;
    logic [63:0] act;
    logic [15:0] wt;
    logic [4:0] em;
    bus.in_valid = 0;
    bus.in_last = 0;
    bus.activation = '0;
    bus.weight = '0;
    bus.signed_w = 0;
    bus.exp_min = 5'd15;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_acc_out", longint'(bus.acc_out), 0);
    check("rst_overflow", longint'(bus.overflow), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_in_ready", longint'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", longint'(bus.in_ready), 1);

    // 1: latency and basic dot product
    send({4{16'h3C00}}, {4{4'd3}}, 1'b1, 5'd15, 1'b1);
    #1;
    t0 = cyc;
    idle();
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", longint'(cyc - t0), 3);
    drain();
    check("s1_acc", got_q[$].acc, 12288);
    check("s1_ovf", longint'(got_q[$].ovf), 0);

    // 2, 3, 6: sign handling, truncating right shift, weight extremes, Inf lane
    run_vec("s2", {16'h0, 16'h0, 16'h3800, 16'hC000}, {4'd0, 4'd0, 4'd1, 4'd1}, 1'b1, -1536, 1'b0);
    run_vec("s3_signed", {48'h0, 16'h3C00}, {12'h0, 4'b1000}, 1'b1, -8192, 1'b0);
    run_vec("s3_unsigned", {48'h0, 16'h3C00}, {12'h0, 4'b1000}, 1'b0, 8192, 1'b0);
    run_vec("s6_inf", {16'h3C00, 16'h3C00, 16'h3C00, 16'h7C00}, {4'd1, 4'd1, 4'd1, 4'd3}, 1'b1, 3072, 1'b1);

    // 4: two-beat saturation, then a clean vector
    drain();
    send({4{16'h7BFF}}, {4{4'd7}}, 1'b1, 5'd15, 1'b0);
    send({4{16'h7BFF}}, {4{4'd7}}, 1'b1, 5'd15, 1'b1);
    idle();
    drain();
    check("s4_acc", got_q[$].acc, 64'sd2147483647);
    check("s4_ovf", longint'(got_q[$].ovf), 1);
    run_vec("s4_next", {4{16'h3C00}}, {4{4'd3}}, 1'b1, 12288, 1'b0);

    // 5: result held while the stream keeps pushing
    drain();
    base = got_q.size();
    ready_force = 0;
    fork
      begin
        send({4{16'h3C00}}, {4{4'd3}}, 1'b1, 5'd15, 1'b1);
        send({4{16'h4000}}, {4{4'd1}}, 1'b1, 5'd15, 1'b0);
        send({4{16'h4000}}, {4{4'd1}}, 1'b1, 5'd15, 1'b1);
        send({16'h0, 16'h0, 16'h3800, 16'hC000}, {4'd0, 4'd0, 4'd1, 4'd1}, 1'b1, 5'd15, 1'b1);
        idle();
      end
      begin
        repeat (15) @(negedge clk);
        ready_force = 1;
      end
    join
    drain();
    check("s5_count", longint'(got_q.size() - base), 3);
    check("s5_r0", got_q[base].acc, 12288);
    check("s5_r1", got_q[base+1].acc, 16384);
    check("s5_r2", got_q[base+2].acc, -1536);

    // 7: reset mid-vector
    send({4{16'h3C00}}, {4{4'd2}}, 1'b1, 5'd15, 1'b0);
    send({4{16'h3C00}}, {4{4'd2}}, 1'b1, 5'd15, 1'b0);
    @(negedge clk);
    bus.in_valid = 0;
    rst_n = 0;
    m_acc = 0;
    m_flag = 0;
    #1;
    check("s7_out_valid", longint'(bus.out_valid), 0);
    check("s7_acc_out", longint'(bus.acc_out), 0);
    check("s7_overflow", longint'(bus.overflow), 0);
    check("s7_busy", longint'(busy), 0);
    check("s7_in_ready", longint'(bus.in_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    check("s7_in_ready_pre", longint'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    check("s7_in_ready_post", longint'(bus.in_ready), 1);
    run_vec("s7_clean", {4{16'h3C00}}, {4{4'd3}}, 1'b1, 12288, 1'b0);

    // randomized stream with random back-pressure
    rnd_ready = 1;
    for (int b = 0; b < 300; b++) begin
      em = 5'($urandom_range(8, 22));
      for (int i = 0; i < L; i++) begin
        act[16*i +: 16] = rnd_act(int'(em));
        wt[4*i +: 4] = 4'($urandom);
      end
      send(act, wt, 1'($urandom_range(0, 1)), em, (b == 299) || ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    drain();
    rnd_ready = 0;
    check("final_queue_empty", longint'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
